seq_addsub: RTL and testbench

Parametrised, multi-cycle binary adder/subtractor. It adds or subtracts two WIDTH-bit operands in CHUNK-bit slices, one slice per clock, and carries between slices through a register. It also reports carry, signed overflow, zero and negative flags. It replaces the 4-bit combinational adder/subtractor where operand widths are too wide for single-cycle ripple, and it uses a start/busy/done handshake to talk to the surrounding datapath controller.

---
 rtl/seq_addsub.sv | 117 +++++++++++
 tb/tb_seq_addsub.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/seq_addsub.sv
// seq_addsub: multi-cycle adder/subtractor processing CHUNK bits per clock
// Ports:
//   clk, rst              clock and asynchronous active-high reset
//   start                 request, sampled only while idle
//   a, b, cin, sub        operands, carry/borrow-in and mode, latched on accept
//   busy                  high while slices are being computed
//   done                  one-cycle pulse when result and flags update
//   result                last completed result
//   cout, ovf, zero, neg  final carry, signed overflow, result==0, result MSB
module seq_addsub #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovf,
   output logic             zero,
   output logic             neg
);
   localparam int NSLICE = WIDTH / CHUNK;
   localparam int KW = NSLICE > 1 ? $clog2(NSLICE) : 1;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, result_q, result_d, acc_n;
   logic carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d, neg_q, neg_d;
   logic [KW-1:0] k_q, k_d;
   logic [CHUNK:0] sum;
   logic last;
   // Operands shift down one slice per cycle so the active slice is always
   // the low CHUNK bits; the accumulator fills from the top, so after NSLICE
   // shifts slice 0 sits at the bottom.
   always_comb begin
      sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
      acc_n = (WIDTH'(sum[CHUNK-1:0]) << (WIDTH - CHUNK)) | (acc_q >> CHUNK);
      last = k_q == KW'(NSLICE - 1);
      state_d = state_q;
      a_d = a_q;
      b_d = b_q;
      acc_d = acc_q;
      carry_d = carry_q;
      k_d = k_q;
      result_d = result_q;
      cout_d = cout_q;
      ovf_d = ovf_q;
      zero_d = zero_q;
      neg_d = neg_q;
      case (state_q)
         IDLE: if (start) begin
            a_d = a;
            b_d = b ^ {WIDTH{sub}};
            carry_d = cin ^ sub;
            k_d = '0;
            state_d = RUN;
         end
         RUN: begin
            a_d = a_q >> CHUNK;
            b_d = b_q >> CHUNK;
            acc_d = acc_n;
            carry_d = sum[CHUNK];
            k_d = k_q + KW'(1);
            if (last) begin
               state_d = DONE;
               result_d = acc_n;
               cout_d = sum[CHUNK];
               // on the last slice the low bits of a_q/b_q hold the operand MSBs
               ovf_d = (a_q[CHUNK-1] == b_q[CHUNK-1]) && (sum[CHUNK-1] != a_q[CHUNK-1]);
               zero_d = acc_n == '0;
               neg_d = acc_n[WIDTH-1];
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q <= '0;
         b_q <= '0;
         acc_q <= '0;
         carry_q <= 1'b0;
         k_q <= '0;
         result_q <= '0;
         cout_q <= 1'b0;
         ovf_q <= 1'b0;
         zero_q <= 1'b0;
         neg_q <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q <= a_d;
         b_q <= b_d;
         acc_q <= acc_d;
         carry_q <= carry_d;
         k_q <= k_d;
         result_q <= result_d;
         cout_q <= cout_d;
         ovf_q <= ovf_d;
         zero_q <= zero_d;
         neg_q <= neg_d;
      end
   end
   assign busy = state_q == RUN;
   assign done = state_q == DONE;
   assign result = result_q;
   assign cout = cout_q;
   assign ovf = ovf_q;
   assign zero = zero_q;
   assign neg = neg_q;
endmodule

// File: tb/tb_seq_addsub.sv
// tb_seq_addsub: scoreboard bench for seq_addsub at 16/4 and 8/8
module tb_seq_addsub;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;
   logic s16 = 0, cin16 = 0, sub16 = 0, s8 = 0, cin8 = 0, sub8 = 0;
   logic [15:0] a16 = 0, b16 = 0, res16;
   logic [7:0] a8 = 0, b8 = 0, res8;
   logic busy16, done16, cout16, ovf16, zero16, neg16;
   logic busy8, done8, cout8, ovf8, zero8, neg8;
   typedef struct packed {logic [15:0] r; logic c, o, z, n;} exp_t;
   exp_t q16[$], q8[$];
   exp_t e16, e8;
   logic [15:0] last16 = 0;
   int checks = 0, errors = 0;

   seq_addsub #(.WIDTH(16), .CHUNK(4)) dut16 (.clk(clk), .rst(rst), .start(s16), .a(a16), .b(b16),
      .cin(cin16), .sub(sub16), .busy(busy16), .done(done16), .result(res16), .cout(cout16),
      .ovf(ovf16), .zero(zero16), .neg(neg16));
   seq_addsub #(.WIDTH(8), .CHUNK(8)) dut8 (.clk(clk), .rst(rst), .start(s8), .a(a8), .b(b8),
      .cin(cin8), .sub(sub8), .busy(busy8), .done(done8), .result(res8), .cout(cout8),
      .ovf(ovf8), .zero(zero8), .neg(neg8));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: plain integer arithmetic; overflow from the signed sum range.
   function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                  input logic s, input logic ci);
      exp_t e;
      longint m, half, bp, c0, full, sa, sb, ss;
      m = (64'sd1 << w) - 1;
      half = 64'sd1 << (w - 1);
      bp = s ? (~longint'(b)) & m : longint'(b);
      c0 = longint'(ci ^ s);
      full = longint'(a) + bp + c0;
      sa = longint'(a) >= half ? longint'(a) - (m + 1) : longint'(a);
      sb = bp >= half ? bp - (m + 1) : bp;
      ss = sa + sb + c0;
      e.r = 16'(full & m);
      e.c = ((full >> w) & 1) == 1;
      e.o = ss >= half || ss < -half;
      e.z = e.r == 0;
      e.n = e.r[w-1];
      return e;
   endfunction

   always @(posedge clk) begin
      #1;
      if (done16) begin
         if (q16.size() == 0) chk("dut16_unexpected_done", 1, 0);
         else begin
            e16 = q16.pop_front();
            chk("res16", res16, e16.r);
            chk("cout16", cout16, e16.c);
            chk("ovf16", ovf16, e16.o);
            chk("zero16", zero16, e16.z);
            chk("neg16", neg16, e16.n);
            chk("busy_with_done16", busy16, 0);
         end
      end
      if (done8) begin
         if (q8.size() == 0) chk("dut8_unexpected_done", 1, 0);
         else begin
            e8 = q8.pop_front();
            chk("res8", res8, e8.r);
            chk("cout8", cout8, e8.c);
            chk("ovf8", ovf8, e8.o);
            chk("zero8", zero8, e8.z);
            chk("neg8", neg8, e8.n);
            chk("busy_with_done8", busy8, 0);
         end
      end
   end

   task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic s, input logic ci,
                       input bit poke);
      exp_t e;
      e = model(16, a, b, s, ci);
      @(negedge clk);
      a16 = a; b16 = b; sub16 = s; cin16 = ci; s16 = 1;
      q16.push_back(e);
      @(posedge clk); #1;
      s16 = 0;
      chk("busy16_accept", busy16, 1);
      for (int j = 1; j <= 4; j++) begin
         if (poke && j == 1) begin
            @(negedge clk);
            s16 = 1; a16 = ~a; b16 = a ^ 16'h5a5a; sub16 = ~s; cin16 = ~ci;
         end
         @(posedge clk); #1;
         s16 = 0;
         chk("busy16_run", busy16, j < 4);
         chk("done16_time", done16, j == 4);
         if (j < 4) chk("hold16", res16, last16);
      end
      last16 = e.r;
      @(posedge clk); #1;
      chk("done16_off", done16, 0);
   endtask

   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s, input logic ci);
      @(negedge clk);
      a8 = a; b8 = b; sub8 = s; cin8 = ci; s8 = 1;
      q8.push_back(model(8, {8'h0, a}, {8'h0, b}, s, ci));
      @(posedge clk); #1;
      s8 = 0;
      chk("busy8_accept", busy8, 1);
      @(posedge clk); #1;
      chk("done8_time", done8, 1);
      @(posedge clk); #1;
      chk("done8_off", done8, 0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_res16", res16, 0);
      chk("rst_zero16", zero16, 0);
      chk("rst_busy16", busy16, 0);
      chk("rst_done16", done16, 0);
      chk("rst_res8", res8, 0);
      @(negedge clk) rst = 0;
      op16(16'h0006, 16'h000C, 1, 0, 0);
      chk("dir_fffa", res16, 16'hFFFA);
      chk("dir_fffa_cout", cout16, 0);
      chk("dir_fffa_neg", neg16, 1);
      op16(16'h0FFF, 16'h0001, 0, 0, 0);
      chk("dir_1000", res16, 16'h1000);
      op16(16'hFFFF, 16'h0001, 0, 0, 0);
      chk("dir_wrap_zero", zero16, 1);
      op16(16'h7FFF, 16'h0001, 0, 0, 0);
      chk("dir_ovf_add", ovf16, 1);
      op16(16'h8000, 16'h0001, 1, 0, 0);
      chk("dir_ovf_sub", ovf16, 1);
      op16(16'h1234, 16'h1234, 1, 0, 0);
      op16(16'h1234, 16'h1234, 1, 1, 0);
      chk("dir_ffff", res16, 16'hFFFF);
      op16(16'h1111, 16'h2222, 0, 0, 1);
      chk("poke_ignored", res16, 16'h3333);
      for (int i = 0; i < 300; i++)
         op16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      op16(16'h8765, 16'h1234, 1, 1, 0);
      @(negedge clk);
      a16 = 16'hABCD; b16 = 16'h1111; sub16 = 0; cin16 = 0; s16 = 1;
      @(posedge clk); #1;
      s16 = 0;
      repeat (2) @(posedge clk);
      #3;
      rst = 1;
      #1;
      chk("arst_res16", res16, 0);
      chk("arst_flags16", {cout16, ovf16, zero16, neg16}, 0);
      chk("arst_busy16", busy16, 0);
      chk("arst_done16", done16, 0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 0;
      last16 = 0;
      repeat (3) @(posedge clk);
      op16(16'h0003, 16'h0004, 0, 0, 0);
      chk("after_rst_7", res16, 16'h0007);
      op8(8'h00, 8'h00, 0, 0);
      op8(8'hFF, 8'h01, 0, 0);
      op8(8'h7F, 8'h01, 0, 0);
      op8(8'h80, 8'h01, 1, 0);
      op8(8'h00, 8'h01, 1, 1);
      op8(8'hFF, 8'hFF, 0, 1);
      for (int i = 0; i < 3000; i++)
         op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      repeat (3) @(posedge clk);
      chk("q16_drained", q16.size(), 0);
      chk("q8_drained", q8.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
